alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream command/operand front-end for the 8-bit ALU stage. It assembles an opcode byte and two operand bytes from a narrow byte stream (valid/ready), presents registered sel/in1/in2 to the combinational ALU, and captures the 16-bit ALU result. It returns the result as two bytes, low then high, over a second valid/ready stream. It lets the 8-pin-limited top level drive all ALU operations without a wide operand bus.

Parameters:
OPCODE_MAX, 12, highest legal opcode; any opcode above it is flagged illegal.
TIMEOUT_CYCLES, 255, idle cycles allowed between bytes of one frame before the frame is abandoned (1..255).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  8  command byte stream
data_valid  input  1  data_in valid
data_ready  output  1  sequencer accepts data_in this cycle
alu_sel  output  4  registered opcode to ALU
alu_in1  output  8  registered operand 1 to ALU
alu_in2  output  8  registered operand 2 to ALU
alu_result  input  16  combinational ALU result
res_data  output  8  result byte
res_valid  output  1  res_data valid
res_ready  input  1  downstream accepts res_data
res_err  output  1  qualifies res_valid: frame had an illegal opcode
timeout_err  output  1  one-cycle pulse: frame abandoned on timeout
op_count  output  8  completed operations, wraps 255->0

Behaviour:
- Reset (rst=1 at edge): state S_OP; alu_sel/alu_in1/alu_in2=0; result reg=0; res_valid=0; res_err=0; timeout_err=0; op_count=0; timer=0. rst overrides everything, including mid-frame and mid-result; partial frames are discarded.
- A byte is accepted when data_valid && data_ready. data_ready=1 only in S_OP, S_A and S_B. It is purely a state decode, so it is 1 in the first cycle after reset.
- States:
  - S_OP: on accept, opcode_reg <= data_in[3:0] (data_in[7:4] ignored); illegal <= (data_in[3:0] > OPCODE_MAX); go to S_A.
  - S_A: on accept, alu_in1 <= data_in; go to S_B.
  - S_B: on accept, alu_in2 <= data_in; alu_sel <= opcode_reg; go to S_EXEC.
  - S_EXEC: one cycle, ALU inputs stable; at edge, result reg <= illegal ? 16'h0000 : alu_result; go to S_RES_LO.
  - S_RES_LO: res_valid=1, res_data=result[7:0]; on res_ready go to S_RES_HI.
  - S_RES_HI: res_valid=1, res_data=result[15:8]; on res_ready, op_count++ and go to S_OP.
- Latency: res_valid rises 2 cycles after the edge that accepts operand 2. Minimum frame is 3 input cycles + 1 exec cycle + 2 output cycles.
- res_err equals the frame's illegal flag while res_valid=1, else 0. alu_sel/in1/in2 hold their last values outside S_EXEC.
- Backpressure: res_data and res_valid are held stable while res_ready=0, with no limit and no timeout. data_ready=0 throughout result output.
- Timeout applies only in S_A/S_B:
  - The timer clears on entry and on each accept, and increments on each cycle without an accept.
  - When it reaches TIMEOUT_CYCLES: go to S_OP, assert timeout_err for exactly 1 cycle, do not change op_count, leave the ALU operand registers untouched.
  - A byte arriving in the same cycle the timer reaches the limit is accepted; accept has priority over timeout.
- Illegal-opcode frames still consume both operand bytes, still return two bytes (0x00, 0x00), and still increment op_count.

Decomposition:
- Shared package alu_pkg: 4-bit opcode constants OP_ADD(0) through OP_GT(12), OPCODE_W=4, DATA_W=8, RESULT_W=16, and the sequencer state encoding. The existing ALU stage also uses the opcode constants.
- One sub-module, alu_seq_timer: the loadable/clearable frame timeout counter with a terminal-count output.

Test Plan:
The bench connects a reference ALU model to alu_result.
- Add: bytes 0x00,0x12,0x34 -> res bytes 0x46 then 0x00, res_err=0, op_count=1; res_valid rises 2 cycles after the 0x34 accept.
- Multiply plus opcode nibble mask: bytes 0xF2,0xFF,0xFF (opcode 2) -> 0x01 then 0xFE (0xFE01).
- Illegal opcode: bytes 0x0D,0x05,0x06 -> 0x00,0x00 with res_err=1 on both bytes; op_count increments.
- Timeout: byte 0x00 then idle 255 cycles -> timeout_err single pulse, state S_OP. Next bytes 0x04,0xF0,0x3C -> 0x30,0x00.
- Backpressure: add 0x01,0x01 with res_ready=0 for 10 cycles -> res_data stays 0x02, data_ready=0 throughout, and data_valid pulses are ignored.
- Reset mid-frame: send 0x00,0x11, assert rst for 1 cycle, then send 0x00,0x01,0x02 -> 0x03,0x00; op_count=1 afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU stage and its command sequencer:
// opcode map, datapath widths and the sequencer state encoding.
package alu_pkg;

    localparam int OPCODE_W = 4;
    localparam int DATA_W   = 8;
    localparam int RESULT_W = 16;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_DIV = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_NOT = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_SHL = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_SHR = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_ROL = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_EQ  = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_GT  = 4'd12;

    typedef enum logic [2:0] {
        S_OP,
        S_A,
        S_B,
        S_EXEC,
        S_RES_LO,
        S_RES_HI
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream command input and result output of the ALU command sequencer.
interface alu_cmd_sequencer_if import alu_pkg::*; ();

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_err;

    modport slave (
        input  data_in, data_valid, res_ready,
        output data_ready, res_data, res_valid, res_err
    );

    modport master (
        output data_in, data_valid, res_ready,
        input  data_ready, res_data, res_valid, res_err
    );

endinterface

// File: rtl/alu_seq_timer.sv
// Inter-byte idle counter for a command frame; tc flags the idle cycle
// that exhausts the allowance.
module alu_seq_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // An accept on the same cycle suppresses tc, giving the byte priority.
    assign tc = run && !clear && (count == CW'(LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || !run || clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Assembles opcode/operand bytes into registered ALU inputs, captures the
// 16-bit result and streams it back low byte first.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int OPCODE_MAX     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic [OPCODE_W-1:0]  alu_sel,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    input  logic [RESULT_W-1:0]  alu_result,
    output logic                 timeout_err,
    output logic [7:0]           op_count
);

    seq_state_t          state, state_next;
    logic [OPCODE_W-1:0] opcode_reg;
    logic                illegal;
    logic [RESULT_W-1:0] result;
    logic                accept;
    logic                timer_run;
    logic                timer_tc;

    assign bus.data_ready = (state == S_OP) || (state == S_A) || (state == S_B);
    assign accept         = bus.data_valid && bus.data_ready;
    assign timer_run      = (state == S_A) || (state == S_B);

    assign bus.res_valid  = (state == S_RES_LO) || (state == S_RES_HI);
    assign bus.res_data   = (state == S_RES_HI) ? result[15:8] : result[7:0];
    assign bus.res_err    = bus.res_valid && illegal;

    alu_seq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (timer_run),
        .clear (accept),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OP;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_OP:     if (accept) state_next = S_A;
            S_A:      if (accept) state_next = S_B;
                      else if (timer_tc) state_next = S_OP;
            S_B:      if (accept) state_next = S_EXEC;
                      else if (timer_tc) state_next = S_OP;
            S_EXEC:   state_next = S_RES_LO;
            S_RES_LO: if (bus.res_ready) state_next = S_RES_HI;
            S_RES_HI: if (bus.res_ready) state_next = S_OP;
            default:  state_next = S_OP;
        endcase
    end

    // NOTE: every register here is reset, so a frame cut short by rst leaves
    // no stale opcode, illegal flag or result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_reg  <= '0;
            illegal     <= 1'b0;
            alu_sel     <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            result      <= '0;
            timeout_err <= 1'b0;
            op_count    <= '0;
        end else begin
            timeout_err <= timer_tc;
            if (accept && state == S_OP) begin
                opcode_reg <= bus.data_in[OPCODE_W-1:0];
                illegal    <= int'(bus.data_in[OPCODE_W-1:0]) > OPCODE_MAX;
            end
            if (accept && state == S_A) begin
                alu_in1 <= bus.data_in;
            end
            if (accept && state == S_B) begin
                alu_in2 <= bus.data_in;
                alu_sel <= opcode_reg;
            end
            // Illegal frames still return a (zero) result to keep framing intact.
            if (state == S_EXEC) begin
                result <= illegal ? '0 : alu_result;
            end
            if (state == S_RES_HI && bus.res_ready) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a reference ALU on alu_result and
// a queue-based scoreboard checked by an independent result monitor.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [OPCODE_W-1:0] alu_sel;
    logic [DATA_W-1:0]   alu_in1;
    logic [DATA_W-1:0]   alu_in2;
    logic [RESULT_W-1:0] alu_result;
    logic                timeout_err;
    logic [7:0]          op_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(
        .OPCODE_MAX     (12),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .alu_sel     (alu_sel),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_result  (alu_result),
        .timeout_err (timeout_err),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU stage.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            OP_ADD: alu_result = {8'h00, alu_in1} + {8'h00, alu_in2};
            OP_SUB: alu_result = {8'h00, alu_in1} - {8'h00, alu_in2};
            OP_MUL: alu_result = alu_in1 * alu_in2;
            OP_DIV: alu_result = (alu_in2 == 0) ? 16'hFFFF : {8'h00, alu_in1 / alu_in2};
            OP_AND: alu_result = {8'h00, alu_in1 & alu_in2};
            OP_OR:  alu_result = {8'h00, alu_in1 | alu_in2};
            OP_XOR: alu_result = {8'h00, alu_in1 ^ alu_in2};
            OP_NOT: alu_result = {8'h00, ~alu_in1};
            OP_SHL: alu_result = {8'h00, alu_in1} << alu_in2[2:0];
            OP_SHR: alu_result = {8'h00, alu_in1 >> alu_in2[2:0]};
            OP_ROL: alu_result = {8'h00, alu_in1[6:0], alu_in1[7]};
            OP_EQ:  alu_result = {15'h0, alu_in1 == alu_in2};
            OP_GT:  alu_result = {15'h0, alu_in1 > alu_in2};
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: every handshaken result byte is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result_byte", {23'h0, bus.res_data, bus.res_err}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("res_data", {24'h0, bus.res_data}, {24'h0, e.data});
                    check("res_err", {31'h0, bus.res_err}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("data_ready_wait", {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic expect_pair(input logic [7:0] lo, input logic [7:0] hi, input logic err);
        sb.push_back('{data: lo, err: err});
        sb.push_back('{data: hi, err: err});
    endtask

    task automatic wait_done(input logic [7:0] exp_count, input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (op_count == exp_count && bus.data_ready && sb.size() == 0) break;
        end
        check(name, {24'h0, op_count}, {24'h0, exp_count});
        check({name, "_sb_empty"}, sb.size(), 32'h0);
    endtask

    initial begin
        int pulses;
        int first;

        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_data_ready", {31'h0, bus.data_ready}, 32'h1);
        check("rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
        check("rst_op_count", {24'h0, op_count}, 32'h0);
        check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
        check("rst_alu_in1", {24'h0, alu_in1}, 32'h0);
        check("rst_alu_sel", {28'h0, alu_sel}, 32'h0);
        @(posedge clk);
        #1;

        // Add, with result latency.
        expect_pair(8'h46, 8'h00, 1'b0);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("lat_exec_res_valid", {31'h0, bus.res_valid}, 32'h0);
        @(negedge clk);
        check("lat_res_valid_rise", {31'h0, bus.res_valid}, 32'h1);
        wait_done(8'd1, "add_op_count");

        // Multiply with upper opcode nibble masked off.
        @(posedge clk);
        #1;
        expect_pair(8'h01, 8'hFE, 1'b0);
        send_byte(8'hF2);
        send_byte(8'hFF);
        send_byte(8'hFF);
        wait_done(8'd2, "mul_op_count");

        // Illegal opcode.
        @(posedge clk);
        #1;
        expect_pair(8'h00, 8'h00, 1'b1);
        send_byte(8'h0D);
        send_byte(8'h05);
        send_byte(8'h06);
        wait_done(8'd3, "illegal_op_count");

        // Timeout after one byte and 255 idle cycles.
        @(posedge clk);
        #1;
        send_byte(8'h00);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("timeout_pulses", pulses, 32'd1);
        check("timeout_cycle", first, 32'd256);
        check("timeout_op_count", {24'h0, op_count}, 32'd3);
        check("timeout_alu_in1_kept", {24'h0, alu_in1}, 32'h05);
        check("timeout_alu_in2_kept", {24'h0, alu_in2}, 32'h06);
        check("timeout_data_ready", {31'h0, bus.data_ready}, 32'h1);
        @(posedge clk);
        #1;
        expect_pair(8'h30, 8'h00, 1'b0);
        send_byte(8'h04);
        send_byte(8'hF0);
        send_byte(8'h3C);
        wait_done(8'd4, "post_timeout_op_count");

        // Backpressure with ignored data_valid pulses.
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        expect_pair(8'h02, 8'h00, 1'b0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.data_in    = 8'hAA;
            bus.data_valid = i[0];
            @(negedge clk);
            check("bp_res_valid", {31'h0, bus.res_valid}, 32'h1);
            check("bp_res_data", {24'h0, bus.res_data}, 32'h02);
            check("bp_data_ready", {31'h0, bus.data_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.res_ready  = 1'b1;
        wait_done(8'd5, "bp_op_count");

        // Reset mid-frame.
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_op_count", {24'h0, op_count}, 32'h0);
        check("midrst_data_ready", {31'h0, bus.data_ready}, 32'h1);
        check("midrst_alu_in1", {24'h0, alu_in1}, 32'h0);
        @(posedge clk);
        #1;
        expect_pair(8'h03, 8'h00, 1'b0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_done(8'd1, "midrst_final_op_count");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
